// File: rtl/pingpong_pkg.sv
// Shared state encoding and direction constants for the ping-pong step counter.
package pingpong_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWELL = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pingpong_next_val.sv
// Combinational step/clamp unit: one move of the count toward the active bound.
// All arithmetic is WIDTH+1 bits so neither direction can wrap.
module pingpong_next_val
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic             dir,
    output logic [WIDTH-1:0] next_out,
    output logic             hit_end
);

    logic [WIDTH:0] step_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] min_plus;

    always_comb begin
        step_x   = (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
        sum      = {1'b0, cur} + step_x;
        min_plus = {1'b0, min} + step_x;
        next_out = cur;
        hit_end  = 1'b0;
        if (dir == DIR_UP) begin
            if (sum >= {1'b0, max}) begin
                next_out = max;
                hit_end  = 1'b1;
            end else begin
                next_out = sum[WIDTH-1:0];
            end
        end else begin
            // cur < min+step or cur-step == min, folded into one compare
            if ({1'b0, cur} <= min_plus) begin
                next_out = min;
                hit_end  = 1'b1;
            end else begin
                next_out = cur - step_x[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/pingpong_step_counter.sv
// Ping-pong counter bouncing between run-time min/max with step, endpoint dwell,
// turn pulse and range fault. PINGPONG_TURN_COUNT_EN adds a saturating turn_cnt output.
//
// state | meaning
// RUN   | moving one step per enabled cycle
// DWELL | holding at an endpoint for DWELL_CYC enabled cycles
// HALT  | range invalid; count and direction frozen, fault high
module pingpong_step_counter
    import pingpong_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DWELL_CYC = 0,
    parameter int DWELL_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             turn,
    output logic             fault
`ifdef PINGPONG_TURN_COUNT_EN
    ,
    output logic [15:0]      turn_cnt
`endif
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               dir_q, dir_d;
    logic               turn_q, turn_d;
    logic               fault_q, fault_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               valid;
    logic               step_dir;
    logic [WIDTH-1:0]   nv_out;
    logic               nv_hit;

    assign valid    = (max > min) && (out_q >= min) && (out_q <= max);
    assign step_dir = flip ? ~dir_q : dir_q;

    pingpong_next_val #(.WIDTH(WIDTH)) u_next_val (
        .cur      (out_q),
        .step     (step),
        .min      (min),
        .max      (max),
        .dir      (step_dir),
        .next_out (nv_out),
        .hit_end  (nv_hit)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        dir_d   = dir_q;
        turn_d  = 1'b0;
        fault_d = 1'b0;
        dwell_d = dwell_q;
        if (!valid) begin
            state_d = HALT;
            fault_d = 1'b1;
            dwell_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        out_d = nv_out;
                        if (nv_hit) begin
                            // a clamp always reverses relative to the direction just used
                            dir_d  = ~step_dir;
                            turn_d = 1'b1;
                            if (DWELL_CYC > 0) begin
                                state_d = DWELL;
                            end
                        end else begin
                            dir_d = step_dir;
                        end
                    end
                end
                DWELL: begin
                    if (enable) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = RUN;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DWELL_W'(1);
                        end
                    end
                end
                HALT: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    dwell_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            out_q   <= min;
            dir_q   <= DIR_UP;
            turn_q  <= 1'b0;
            fault_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            fault_q <= fault_d;
            dwell_q <= dwell_d;
        end
    end

    assign out       = out_q;
    assign direction = dir_q;
    assign turn      = turn_q;
    assign fault     = fault_q;

`ifdef PINGPONG_TURN_COUNT_EN
    logic [15:0] turn_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt_q <= '0;
        end else if (turn_d && (turn_cnt_q != 16'hFFFF)) begin
            turn_cnt_q <= turn_cnt_q + 16'd1;
        end
    end

    assign turn_cnt = turn_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_step_counter.sv
// Directed bench for pingpong_step_counter: one instance without dwell, one with DWELL_CYC=2.
// Honours PINGPONG_TURN_COUNT_EN when defined.
module tb_pingpong_step_counter;

    logic       clk = 1'b0;
    logic       rst, enable, flip;
    logic [3:0] max, min, step;

    logic [3:0] d0_out, d2_out;
    logic       d0_dir, d0_turn, d0_fault;
    logic       d2_dir, d2_turn, d2_fault;
`ifdef PINGPONG_TURN_COUNT_EN
    logic [15:0] d0_tcnt, d2_tcnt;
`endif

    int checks = 0;
    int errors = 0;
    int ex_out[$];
    int ex_trn[$];
    int ex_dir[$];

    always #5 clk = ~clk;

    pingpong_step_counter #(.WIDTH(4), .DWELL_CYC(0), .DWELL_W(4)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .flip(flip),
        .max(max), .min(min), .step(step),
        .out(d0_out), .direction(d0_dir), .turn(d0_turn), .fault(d0_fault)
`ifdef PINGPONG_TURN_COUNT_EN
        , .turn_cnt(d0_tcnt)
`endif
    );

    pingpong_step_counter #(.WIDTH(4), .DWELL_CYC(2), .DWELL_W(4)) u_d2 (
        .clk(clk), .rst(rst), .enable(enable), .flip(flip),
        .max(max), .min(min), .step(step),
        .out(d2_out), .direction(d2_dir), .turn(d2_turn), .fault(d2_fault)
`ifdef PINGPONG_TURN_COUNT_EN
        , .turn_cnt(d2_tcnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Walk d0 through the queued expectations, one enabled edge per entry.
    task automatic run_d0(input string name);
        for (int i = 0; i < ex_out.size(); i++) begin
            tick();
            chk($sformatf("%s_out[%0d]", name, i), 16'(d0_out), 16'(ex_out[i]));
            chk($sformatf("%s_turn[%0d]", name, i), 16'(d0_turn), 16'(ex_trn[i]));
            chk($sformatf("%s_dir[%0d]", name, i), 16'(d0_dir), 16'(ex_dir[i]));
        end
    endtask

    task automatic chk_d0(input string name, input int o, input int t, input int d);
        chk({name, "_out"}, 16'(d0_out), 16'(o));
        chk({name, "_turn"}, 16'(d0_turn), 16'(t));
        chk({name, "_dir"}, 16'(d0_dir), 16'(d));
    endtask

    task automatic chk_d2(input string name, input int o, input int t, input int d);
        chk({name, "_out"}, 16'(d2_out), 16'(o));
        chk({name, "_turn"}, 16'(d2_turn), 16'(t));
        chk({name, "_dir"}, 16'(d2_dir), 16'(d));
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; flip = 1'b0;
        min = 4'd2; max = 4'd8; step = 4'd1;

        // basic bounce, step 1; reset applied with enable low
        enable = 1'b0;
        do_reset();
        chk_d0("rst", 2, 0, 1);
        chk("rst_fault", 16'(d0_fault), 16'd0);
        enable = 1'b1;
        ex_out = '{3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 3};
        ex_trn = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        ex_dir = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        run_d0("s1");

        // step 3 clamps at both ends without overshoot
        min = 4'd0; max = 4'd10; step = 4'd3;
        do_reset();
        chk_d0("s2_rst", 0, 0, 1);
        ex_out = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
        ex_trn = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        ex_dir = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        run_d0("s2");

        // dwell of 2 enabled cycles on the second instance
        min = 4'd2; max = 4'd5; step = 4'd1;
        do_reset();
        tick(); chk_d2("dw_e1", 3, 0, 1);
        tick(); chk_d2("dw_e2", 4, 0, 1);
        tick(); chk_d2("dw_e3", 5, 1, 0);
        tick(); chk_d2("dw_e4", 5, 0, 0);
        tick(); chk_d2("dw_e5", 5, 0, 0);
        tick(); chk_d2("dw_e6", 4, 0, 0);
        tick(); chk_d2("dw_e7", 3, 0, 0);
        tick(); chk_d2("dw_e8", 2, 1, 1);
        enable = 1'b0;
        tick(); chk_d2("dw_hold1", 2, 0, 1);
        tick(); chk_d2("dw_hold2", 2, 0, 1);
        enable = 1'b1; flip = 1'b1;
        tick(); chk_d2("dw_flip1", 2, 0, 1);
        tick(); chk_d2("dw_flip2", 2, 0, 1);
        flip = 1'b0;
        tick(); chk_d2("dw_leave", 3, 0, 1);

        // flip: single, held, and at max while heading down
        min = 4'd2; max = 4'd8; step = 4'd1;
        do_reset();
        tick(); tick(); tick();
        chk_d0("fl_pre", 5, 0, 1);
        flip = 1'b1;
        tick(); chk_d0("fl_one", 4, 0, 0);
        tick(); chk_d0("fl_h1", 5, 0, 1);
        tick(); chk_d0("fl_h2", 4, 0, 0);
        tick(); chk_d0("fl_h3", 5, 0, 1);
        flip = 1'b0;
        tick(); chk_d0("fl_rel", 6, 0, 1);
        tick(); chk_d0("fl_7", 7, 0, 1);
        tick(); chk_d0("fl_max", 8, 1, 0);
        flip = 1'b1;
        tick(); chk_d0("fl_atmax", 8, 1, 0);
        flip = 1'b0;
        tick(); chk_d0("fl_down", 7, 0, 0);

        // range fault and recovery, step 0, enable freeze
        min = 4'd0; max = 4'd8; step = 4'd1;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk_d0("ft_pre", 6, 0, 1);
        min = 4'd9; max = 4'd5;
        tick();
        chk_d0("ft_bad1", 6, 0, 1);
        chk("ft_fault1", 16'(d0_fault), 16'd1);
        tick();
        chk("ft_frozen", 16'(d0_out), 16'd6);
        chk("ft_fault2", 16'(d0_fault), 16'd1);
        min = 4'd0; max = 4'd8;
        tick();
        chk_d0("ft_clear", 6, 0, 1);
        chk("ft_fault3", 16'(d0_fault), 16'd0);
        step = 4'd0;
        tick(); chk_d0("ft_step0", 7, 0, 1);
        enable = 1'b0;
        tick(); chk_d0("ft_en0", 7, 0, 1);
        enable = 1'b1; step = 4'd1; max = 4'd5;
        tick();
        chk("ft_oor_fault", 16'(d0_fault), 16'd1);
        chk("ft_oor_out", 16'(d0_out), 16'd7);
        max = 4'd8;
        tick();
        chk("ft_oor_clr", 16'(d0_fault), 16'd0);
        tick(); chk_d0("ft_resume", 8, 1, 0);

`ifdef PINGPONG_TURN_COUNT_EN
        min = 4'd0; max = 4'd3; step = 4'd1;
        do_reset();
        chk("tc_rst0", d0_tcnt, 16'd0);
        for (int i = 0; i < 24; i++) tick();
        chk("tc_out", 16'(d0_out), 16'd0);
        chk("tc_cnt8", d0_tcnt, 16'd8);
        for (int i = 0; i < 4; i++) tick();
        chk_d0("tc_mid", 2, 0, 0);
        min = 4'd1;
        do_reset();
        chk_d0("tc_rst", 1, 0, 1);
        chk("tc_clr", d0_tcnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_step_counter.md
Name: pingpong_step_counter

Overview:
- Next-generation ping-pong counter: WIDTH-bit value bounces between run-time min and max with a programmable step.
- Adds a configurable dwell at each endpoint, a turn-around pulse and a range-fault flag; keeps enable/flip semantics.
- Used as a pattern/address generator feeding display and LED-scan blocks in the lab designs.

Parameters:
- WIDTH, 4, counter/bound/step width in bits.
- DWELL_CYC, 0, enabled cycles the value holds at an endpoint before reversing motion (0 = none).
- DWELL_W, 4, width of dwell counter; DWELL_CYC must be < 2**DWELL_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  advance permission; 0 freezes all state except reset.
- flip  in  1  level-sampled; reverse direction this cycle.
- max  in  WIDTH  upper bound (inclusive), unsigned.
- min  in  WIDTH  lower bound (inclusive), unsigned.
- step  in  WIDTH  increment magnitude; 0 treated as 1.
- out  out  WIDTH  current count.
- direction  out  1  1 = up, 0 = down.
- turn  out  1  one-cycle pulse the cycle out lands on an endpoint.
- fault  out  1  high while range invalid (state HALT).

Behaviour:
- Reset (rst=1 at edge): out<=min input, direction<=1, turn<=0, fault<=0, state<=RUN, dwell count<=0. Reset overrides enable and flip.
- valid = (max > min) && (min <= out <= max), evaluated combinationally each cycle.
- States: RUN, DWELL, HALT.
- Any state, valid=0: next state HALT, out and direction hold, turn<=0, fault<=1; independent of enable.
- HALT -> RUN when valid=1 (fault<=0 same edge, out holds that cycle).
- enable=0 (valid): nothing changes; turn<=0.
- RUN, enable=1, flip=0: up: sum=out+step in WIDTH+1 bits; if sum >= max then out<=max, direction<=0, turn<=1, enter DWELL if DWELL_CYC>0; else out<=sum. Down: if out < min+step (WIDTH+1 bits) or out-step == min then out<=min, direction<=1, turn<=1, DWELL as above; else out<=out-step.
- RUN, enable=1, flip=1: direction toggled first, then the step rule applied in the new direction in the same cycle (so value moves immediately); clamping/turn rules identical. Flip while sitting at max with direction=0 and toggled to up: sum>=max -> out stays max, direction back to 0, turn=1.
- DWELL: dwell counter increments on enabled cycles; out held; flip ignored; after DWELL_CYC enabled cycles -> RUN, counter cleared. Next RUN cycle moves away from endpoint.
- Arithmetic never wraps: all compares in WIDTH+1 bits.
- Live bound changes take effect next cycle; if out falls outside new range -> HALT.
- turn is a registered pulse, exactly one cycle per endpoint arrival.

Optional Feature:
- Macro PINGPONG_TURN_COUNT_EN.
- Defined: extra output turn_cnt [15:0], increments on each turn pulse, saturates at 16'hFFFF, cleared by rst.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package pingpong_pkg: state encoding constants (RUN=2'd0, DWELL=2'd1, HALT=2'd2), DIR_UP/DIR_DOWN constants.
- Sub-module pingpong_next_val: combinational step/clamp unit (out, step, min, max, direction -> next_out, hit_end). Sequential FSM stays in top.

Test Plan:
- rst with min=2,max=8,step=1,DWELL_CYC=0: out 2,3..8,7..2,3; turn high on cycles out=8 and out=2; direction 0 from the cycle out=8.
- step=3,min=0,max=10: out 0,3,6,9,10,7,4,1,0,3; turn at 10 and 0 (clamp, no overshoot).
- DWELL_CYC=2, min=2,max=5: out 2,3,4,5,5,5,4; enable=0 inside dwell extends hold by that many cycles; flip during dwell ignored.
- Counting up at out=5 (min=2,max=8), flip=1 one cycle: next out=4, direction=0; flip held 3 cycles: 4,5,4,5 pattern.
- min=9,max=5 mid-count: fault=1 next cycle, out frozen; restore min=0,max=8 with out=6: fault=0, resume from 6 in stored direction.
- Macro defined: 4 full bounces min=0,max=3 -> turn_cnt=8; rst mid-count -> out=min, turn_cnt=0, direction=1.
